systolic_sched: RTL and testbench

Tile-level sequencer for the systolic array and its conv_ctrl block. On a start pulse it reads one weight tile from the weight buffer and loads it into the array. It then streams num_vec feature vectors with per-row diagonal skew, and waits until all result beats have drained from the last column. Sits between the layer controller (start/done) and the systolic top, and owns the weight and feature buffer read ports.

---
 rtl/systolic_sched_if.sv | 35 +++
 rtl/systolic_sched.sv | 162 ++++++++++++++++
 tb/tb_systolic_sched.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_sched_if.sv
// Bundle between the layer controller / array side and the tile sequencer.
// The master drives requests and array valid flags; the slave (sequencer) drives strobes and enables.
interface systolic_sched_if #(
    parameter int col    = 4,
    parameter int row    = 4,
    parameter int ADDR_W = 10
);
    logic              start;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] f_base;
    logic [7:0]        num_vec;
    logic [4:0]        weight_dim_in;
    logic              stall;
    logic [col-1:0]    out_en;
    logic              busy;
    logic              done;
    logic              w_rd;
    logic [ADDR_W-1:0] w_addr;
    logic              f_rd;
    logic [ADDR_W-1:0] f_addr;
    logic [col-1:0]    weight_en;
    logic [row-1:0]    in_en;
    logic              conv_ctrl;
    logic [4:0]        weight_dim;

    modport master (
        output start, w_base, f_base, num_vec, weight_dim_in, stall, out_en,
        input  busy, done, w_rd, w_addr, f_rd, f_addr, weight_en, in_en, conv_ctrl, weight_dim
    );

    modport slave (
        input  start, w_base, f_base, num_vec, weight_dim_in, stall, out_en,
        output busy, done, w_rd, w_addr, f_rd, f_addr, weight_en, in_en, conv_ctrl, weight_dim
    );
endinterface

// File: rtl/systolic_sched.sv
// Tile sequencer: loads one weight tile, streams N skewed feature vectors, then waits
// for N result beats from the last array column before pulsing done.
module systolic_sched #(
    parameter int width  = 8,
    parameter int col    = 4,
    parameter int row    = 4,
    parameter int ADDR_W = 10
) (
    input logic             clk,
    input logic             nrst,
    systolic_sched_if.slave bus
);
    localparam int         KW        = $clog2(row) + 1;
    localparam logic [8:0] TLAST_OFS = 9'(row - 2);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [KW-1:0]     k_q;
    logic [8:0]        t_q;
    logic              act_q;
    logic [7:0]        n_q;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_d;
    logic [ADDR_W-1:0] wbase_q;
    logic [ADDR_W-1:0] fbase_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [ADDR_W-1:0] f_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              w_rd_q;
    logic              f_rd_q;
    logic              conv_q;
    logic [col-1:0]    weight_en_q;
    logic [row-1:0]    in_en_q;
    logic [row-1:0]    in_en_d;
    logic [4:0]        wdim_q;
    logic [8:0]        t_inc;
    logic              unused_ok;

    // Only the last column's valid flag matters; the datapath width is carried for the array.
    assign unused_ok = ^{bus.out_en[col-2:0], 1'(width)};
    assign t_inc     = t_q + 9'd1;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.out_en[col-1] && (cnt_q < n_q)) cnt_d = cnt_q + 8'd1;
        in_en_d = '0;
        for (int r = 0; r < row; r++) begin
            in_en_d[r] = ({1'b0, t_q} >= 10'(r)) && ({1'b0, t_q} < 10'(r) + {2'b00, n_q});
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            t_q         <= '0;
            act_q       <= 1'b0;
            n_q         <= '0;
            cnt_q       <= '0;
            wbase_q     <= '0;
            fbase_q     <= '0;
            w_addr_q    <= '0;
            f_addr_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            w_rd_q      <= 1'b0;
            f_rd_q      <= 1'b0;
            conv_q      <= 1'b0;
            weight_en_q <= '0;
            in_en_q     <= '0;
            wdim_q      <= '0;
        end else begin
            // Read data arrives one cycle after each strobe, so enables follow the strobes.
            done_q      <= 1'b0;
            conv_q      <= 1'b0;
            w_rd_q      <= 1'b0;
            f_rd_q      <= 1'b0;
            weight_en_q <= {col{w_rd_q}};
            in_en_q     <= (state_q == STREAM && act_q) ? in_en_d : '0;
            if (state_q == STREAM || state_q == DRAIN) cnt_q <= cnt_d;

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        wbase_q <= bus.w_base;
                        fbase_q <= bus.f_base;
                        n_q     <= bus.num_vec;
                        wdim_q  <= bus.weight_dim_in;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        t_q     <= '0;
                        k_q     <= '0;
                        // An empty tile waits one DRAIN cycle, which exits at once since 0 beats are due.
                        if (bus.num_vec == 8'd0) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q  <= LOAD_W;
                            w_rd_q   <= 1'b1;
                            w_addr_q <= bus.w_base;
                        end
                    end
                end
                LOAD_W: begin
                    if (k_q == KW'(row - 1)) begin
                        state_q  <= STREAM;
                        conv_q   <= 1'b1;
                        t_q      <= '0;
                        act_q    <= 1'b1;
                        f_rd_q   <= 1'b1;
                        f_addr_q <= fbase_q;
                    end else begin
                        k_q      <= k_q + KW'(1);
                        w_rd_q   <= 1'b1;
                        w_addr_q <= wbase_q + ADDR_W'(k_q) + ADDR_W'(1);
                    end
                end
                STREAM: begin
                    // A stalled cycle keeps t; the value already read is not re-issued.
                    if (bus.stall) begin
                        act_q <= 1'b0;
                    end else if (t_q == {1'b0, n_q} + TLAST_OFS) begin
                        state_q <= DRAIN;
                        act_q   <= 1'b0;
                    end else begin
                        t_q   <= t_inc;
                        act_q <= 1'b1;
                        if (t_inc < {1'b0, n_q}) begin
                            f_rd_q   <= 1'b1;
                            f_addr_q <= fbase_q + ADDR_W'(t_inc);
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_d == n_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.w_rd       = w_rd_q;
    assign bus.w_addr     = w_addr_q;
    assign bus.f_rd       = f_rd_q;
    assign bus.f_addr     = f_addr_q;
    assign bus.weight_en  = weight_en_q;
    assign bus.in_en      = in_en_q;
    assign bus.conv_ctrl  = conv_q;
    assign bus.weight_dim = wdim_q;
endmodule

// File: tb/tb_systolic_sched.sv
// Directed bench for systolic_sched: per-cycle stimulus tables, a tile-timeline model that
// derives expected outputs from the start cycle, stall and out_en schedules, and literal pins.
module tb_systolic_sched;
    localparam int NC  = 112;
    localparam int ROW = 4;
    localparam int COL = 4;

    logic clk;
    logic nrst;

    systolic_sched_if #(.col(COL), .row(ROW), .ADDR_W(10)) bus ();

    systolic_sched #(.width(8), .col(COL), .row(ROW), .ADDR_W(10)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Stimulus tables: inputs present during cycle c, sampled at the edge closing cycle c.
    bit         st_nrst  [NC];
    bit         st_start [NC];
    logic [9:0] st_wb    [NC];
    logic [9:0] st_fb    [NC];
    logic [7:0] st_n     [NC];
    logic [4:0] st_wd    [NC];
    bit         st_stall [NC];
    bit [3:0]   st_oe    [NC];

    // Expected outputs during cycle c.
    bit         e_busy [NC];
    bit         e_done [NC];
    bit         e_wrd  [NC];
    logic [9:0] e_waddr[NC];
    bit         e_frd  [NC];
    bit         e_fchk [NC];
    logic [9:0] e_faddr[NC];
    bit [3:0]   e_wen  [NC];
    bit [3:0]   e_inen [NC];
    bit         e_conv [NC];
    logic [4:0] e_wdim [NC];

    int nvec  = 0;
    int nmis  = 0;
    int ndone = 0;

    task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, got, exp);
        end
    endtask

    task automatic sstart(input int c, input logic [9:0] wb, input logic [9:0] fb,
                          input logic [7:0] n, input logic [4:0] wd);
        st_start[c] = 1'b1;
        st_wb[c]    = wb;
        st_fb[c]    = fb;
        st_n[c]     = n;
        st_wd[c]    = wd;
    endtask

    // Timeline of one tile accepted in cycle s; nothing is expected at or after 'abort'.
    task automatic plan(input int s, input logic [9:0] wb, input logic [9:0] fb,
                        input int n, input logic [4:0] wd, input int abort);
        int lim, c, t, d0, b, dn, beats;
        bit held;
        lim = (abort < NC) ? abort : NC;
        for (int x = s + 1; x < NC; x++) e_wdim[x] = (x < lim) ? wd : 5'd0;
        if (n == 0) begin
            d0 = s + 1;
        end else begin
            for (int k = 0; k < ROW; k++) begin
                if (s + 1 + k < lim) begin
                    e_wrd[s+1+k]   = 1'b1;
                    e_waddr[s+1+k] = wb + 10'(k);
                end
                if (s + 2 + k < lim) e_wen[s+2+k] = 4'hF;
            end
            if (s + ROW + 1 < lim) e_conv[s+ROW+1] = 1'b1;
            c    = s + ROW + 1;
            t    = 0;
            held = 1'b0;
            while (c < NC) begin
                if (t < n && c < lim) begin
                    e_fchk[c]  = 1'b1;
                    e_faddr[c] = fb + 10'(t);
                    e_frd[c]   = !held;
                end
                if (!held && c + 1 < lim)
                    for (int r = 0; r < ROW; r++)
                        if (r <= t && t < r + n) e_inen[c+1][r] = 1'b1;
                if (st_stall[c]) begin
                    held = 1'b1;
                end else begin
                    held = 1'b0;
                    if (t == n + ROW - 2) break;
                    t++;
                end
                c++;
            end
            d0 = c + 1;
        end
        b     = d0;
        beats = 0;
        if (n > 0)
            for (int x = s + ROW + 1; x < lim; x++)
                if (st_oe[x][COL-1]) begin
                    beats++;
                    if (beats == n) begin
                        b = x;
                        break;
                    end
                end
        dn = ((b > d0) ? b : d0) + 1;
        for (int x = s + 1; x < dn && x < lim; x++) e_busy[x] = 1'b1;
        if (dn < lim) e_done[dn] = 1'b1;
    endtask

    task automatic apply(input int c);
        nrst              = st_nrst[c];
        bus.start         = st_start[c];
        bus.w_base        = st_wb[c];
        bus.f_base        = st_fb[c];
        bus.num_vec       = st_n[c];
        bus.weight_dim_in = st_wd[c];
        bus.stall         = st_stall[c];
        bus.out_en        = st_oe[c];
    endtask

    task automatic check(input int c);
        chk("busy",       c, 32'(bus.busy),       32'(e_busy[c]));
        chk("done",       c, 32'(bus.done),       32'(e_done[c]));
        chk("w_rd",       c, 32'(bus.w_rd),       32'(e_wrd[c]));
        chk("f_rd",       c, 32'(bus.f_rd),       32'(e_frd[c]));
        chk("weight_en",  c, 32'(bus.weight_en),  32'(e_wen[c]));
        chk("in_en",      c, 32'(bus.in_en),      32'(e_inen[c]));
        chk("conv_ctrl",  c, 32'(bus.conv_ctrl),  32'(e_conv[c]));
        chk("weight_dim", c, 32'(bus.weight_dim), 32'(e_wdim[c]));
        if (e_wrd[c])  chk("w_addr", c, 32'(bus.w_addr), 32'(e_waddr[c]));
        if (e_fchk[c]) chk("f_addr", c, 32'(bus.f_addr), 32'(e_faddr[c]));
        if (bus.done === 1'b1) ndone++;
        case (c)
            6:  chk("lit_t1_waddr_first", c, 32'(bus.w_addr), 32'h010);
            9:  chk("lit_t1_waddr_last",  c, 32'(bus.w_addr), 32'h013);
            11: chk("lit_t1_in_en_t0",    c, 32'(bus.in_en),  32'b0001);
            14: chk("lit_t1_in_en_t3",    c, 32'(bus.in_en),  32'b1110);
            19: chk("lit_t1_done",        c, 32'(bus.done),   32'd1);
            33: begin
                chk("lit_t2_held_frd",   c, 32'(bus.f_rd),   32'd0);
                chk("lit_t2_held_faddr", c, 32'(bus.f_addr), 32'h202);
            end
            36: chk("lit_t2_faddr_t4",    c, 32'(bus.f_addr), 32'h204);
            44: chk("lit_t3_n0_done",     c, 32'(bus.done),   32'd1);
            58: chk("lit_t4_wdim_kept",   c, 32'(bus.weight_dim), 32'd7);
            61: chk("lit_t4_done",        c, 32'(bus.done),   32'd1);
            68: chk("lit_t5_wrap0",       c, 32'(bus.w_addr), 32'h000);
            69: chk("lit_t5_wrap1",       c, 32'(bus.w_addr), 32'h001);
            74: chk("lit_t5_reset_busy",  c, 32'(bus.busy),   32'd0);
            90: chk("lit_t6_done",        c, 32'(bus.done),   32'd1);
            91: chk("lit_t6_idle_busy",   c, 32'(bus.busy),   32'd0);
            default: ;
        endcase
    endtask

    initial begin
        for (int x = 0; x < NC; x++) begin
            st_nrst[x] = 1'b1;
            st_wb[x]   = '0;
            st_fb[x]   = '0;
            st_n[x]    = '0;
            st_wd[x]   = '0;
            e_wdim[x]  = '0;
            e_waddr[x] = '0;
            e_faddr[x] = '0;
        end
        for (int x = 0; x < 3; x++) st_nrst[x] = 1'b0;

        // Tile 1: basic; a beat on other columns only must not count.
        sstart(5, 10'h010, 10'h100, 8'd3, 5'd3);
        st_oe[14] = 4'b1000; st_oe[15] = 4'b0111; st_oe[16] = 4'b1000; st_oe[18] = 4'b1000;
        // Tile 2: stall outside STREAM (ignored) and a 2-cycle stall at t=2.
        sstart(25, 10'h020, 10'h200, 8'd5, 5'd4);
        st_stall[27] = 1'b1; st_stall[32] = 1'b1; st_stall[33] = 1'b1;
        for (int x = 36; x <= 40; x++) st_oe[x] = 4'b1000;
        // Start in the DONE cycle is dropped; the next cycle's N=0 start is taken.
        sstart(41, 10'h3AA, 10'h3BB, 8'd7, 5'd30);
        sstart(42, 10'h030, 10'h130, 8'd0, 5'd6);
        // Tile 4: starts while busy, in LOAD_W and in STREAM.
        sstart(50, 10'h040, 10'h140, 8'd2, 5'd7);
        sstart(52, 10'h3FF, 10'h3FF, 8'd9, 5'd31);
        sstart(57, 10'h3FF, 10'h000, 8'd9, 5'd31);
        st_oe[58] = 4'b1000; st_oe[59] = 4'b1000;
        // Tile 5: address wrap, then reset mid-STREAM.
        sstart(65, 10'h3FE, 10'h3FD, 8'd4, 5'd5);
        st_oe[72] = 4'b1000;
        st_nrst[73] = 1'b0;
        // Tile 6: six beats for N=3; tile 7 confirms a clean return to IDLE.
        sstart(78, 10'h050, 10'h150, 8'd3, 5'd9);
        st_oe[85] = 4'b1000; st_oe[86] = 4'b1000; st_oe[87] = 4'b1000;
        st_oe[89] = 4'b1000; st_oe[90] = 4'b1000; st_oe[91] = 4'b1000;
        sstart(95, 10'h060, 10'h160, 8'd1, 5'd2);
        st_oe[102] = 4'b1000;

        plan(5,  10'h010, 10'h100, 3, 5'd3, NC);
        plan(25, 10'h020, 10'h200, 5, 5'd4, NC);
        plan(42, 10'h030, 10'h130, 0, 5'd6, NC);
        plan(50, 10'h040, 10'h140, 2, 5'd7, NC);
        plan(65, 10'h3FE, 10'h3FD, 4, 5'd5, 74);
        plan(78, 10'h050, 10'h150, 3, 5'd9, NC);
        plan(95, 10'h060, 10'h160, 1, 5'd2, NC);

        fork
            begin
                apply(0);
                for (int c = 1; c < NC; c++) begin
                    @(posedge clk);
                    #1;
                    apply(c);
                end
            end
            begin
                for (int c = 0; c < NC; c++) begin
                    @(negedge clk);
                    if (c >= 1) check(c);
                end
            end
        join

        chk("done_pulse_count", NC, 32'(ndone), 32'd6);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
